// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: FSM states, opcodes,
// alu_sel bit positions and IR field locations as functions of the widths.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6
  } seq_state_t;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_ADD = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_AND = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_OR  = 5'b01100;

  localparam int ALU_ADD_BIT = 0;
  localparam int ALU_SUB_BIT = 1;
  localparam int ALU_AND_BIT = 2;
  localparam int ALU_OR_BIT  = 3;

  // Fields are packed MSB-first: opcode, Ra, Rb, Rc, then spare bits.
  function automatic int opcode_msb(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int ra_msb(input int data_w);
    return data_w - OPCODE_W - 1;
  endfunction

  function automatic int rb_msb(input int data_w, input int rsel_w);
    return ra_msb(data_w) - rsel_w;
  endfunction

  function automatic int rc_msb(input int data_w, input int rsel_w);
    return rb_msb(data_w, rsel_w) - rsel_w;
  endfunction

  // A negative result means the register fields fill the word exactly.
  function automatic int spare_msb(input int data_w, input int rsel_w);
    return rc_msb(data_w, rsel_w) - rsel_w;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational IR decode: opcode legality, one-hot ALU select and
// one-hot selects for the Ra/Rb/Rc register fields.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic [DATA_W-1:0]   ir,
  output logic                legal,
  output logic [3:0]          alu_sel,
  output logic [NUM_REGS-1:0] ra_onehot,
  output logic [NUM_REGS-1:0] rb_onehot,
  output logic [NUM_REGS-1:0] rc_onehot
);

  localparam int RSEL_W    = $clog2(NUM_REGS);
  localparam int OPC_MSB   = opcode_msb(DATA_W);
  localparam int RA_MSB    = ra_msb(DATA_W);
  localparam int RB_MSB    = rb_msb(DATA_W, RSEL_W);
  localparam int RC_MSB    = rc_msb(DATA_W, RSEL_W);
  localparam int SPARE_MSB = spare_msb(DATA_W, RSEL_W);

  logic [OPCODE_W-1:0] opcode;
  logic [RSEL_W-1:0]   ra;
  logic [RSEL_W-1:0]   rb;
  logic [RSEL_W-1:0]   rc;

  assign opcode = ir[OPC_MSB -: OPCODE_W];
  assign ra     = ir[RA_MSB -: RSEL_W];
  assign rb     = ir[RB_MSB -: RSEL_W];
  assign rc     = ir[RC_MSB -: RSEL_W];

  always_comb begin
    legal   = 1'b1;
    alu_sel = '0;
    case (opcode)
      OP_ADD:  alu_sel[ALU_ADD_BIT] = 1'b1;
      OP_SUB:  alu_sel[ALU_SUB_BIT] = 1'b1;
      OP_AND:  alu_sel[ALU_AND_BIT] = 1'b1;
      OP_OR:   alu_sel[ALU_OR_BIT]  = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Field values beyond NUM_REGS-1 (non power-of-two counts) decode to all-zero.
  always_comb begin
    ra_onehot = '0;
    rb_onehot = '0;
    rc_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ra_onehot[i] = (ra == RSEL_W'(i));
      rb_onehot[i] = (rb == RSEL_W'(i));
      rc_onehot[i] = (rc == RSEL_W'(i));
    end
  end

  generate
    if (SPARE_MSB >= 0) begin : g_spare
      logic unused_spare_bits;
      assign unused_spare_bits = ^ir[SPARE_MSB:0];
    end
  endgenerate

endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired control sequencer: fetch, IR load and execute of three-register ALU ops.
// Optional ALU_SEQ_MEM_WAIT_EN makes T2 wait for mem_ready before loading MDR.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir_q,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                pc_out,
  output logic                z_low_out,
  output logic                mdr_out,
  output logic                mar_in,
  output logic                pc_in,
  output logic                mdr_in,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                inc_pc,
  output logic                read,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [3:0]          alu_sel
);

  localparam int RSEL_W = $clog2(NUM_REGS);

  generate
    if (OPCODE_W + 3 * RSEL_W > DATA_W) begin : g_bad_params
      $error("alu_op_sequencer: DATA_W too narrow for opcode and three register fields");
    end
  endgenerate

  seq_state_t state, state_next;

  logic                dec_legal;
  logic [3:0]          dec_alu_sel;
  logic [NUM_REGS-1:0] ra_onehot;
  logic [NUM_REGS-1:0] rb_onehot;
  logic [NUM_REGS-1:0] rc_onehot;

  alu_seq_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .ir        (ir_q),
    .legal     (dec_legal),
    .alu_sel   (dec_alu_sel),
    .ra_onehot (ra_onehot),
    .rb_onehot (rb_onehot),
    .rc_onehot (rc_onehot)
  );

`ifdef ALU_SEQ_MEM_WAIT_EN
  logic mem_go;
  assign mem_go = mem_ready;
`else
  logic mem_go;
  logic unused_mem_ready;
  assign mem_go           = 1'b1;
  assign unused_mem_ready = mem_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = T0;
      T0:      state_next = T1;
      T1:      state_next = T2;
      T2:      if (mem_go) state_next = T3;
      T3:      state_next = T4;
      T4:      state_next = dec_legal ? T5 : IDLE;
      T5:      state_next = T6;
      T6:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sticky until the next instruction is actually accepted out of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (state == IDLE && start) begin
      illegal <= 1'b0;
    end else if (state == T4 && !dec_legal) begin
      illegal <= 1'b1;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = 1'b0;
    pc_out    = 1'b0;
    z_low_out = 1'b0;
    mdr_out   = 1'b0;
    mar_in    = 1'b0;
    pc_in     = 1'b0;
    mdr_in    = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    inc_pc    = 1'b0;
    read      = 1'b0;
    reg_out   = '0;
    reg_in    = '0;
    alu_sel   = '0;
    case (state)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      T1: begin
        z_low_out = 1'b1;
        pc_in     = 1'b1;
        read      = 1'b1;
      end
      T2: begin
        read   = 1'b1;
        mdr_in = mem_go;
      end
      T3: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T4: begin
        if (dec_legal) begin
          reg_out = rb_onehot;
          y_in    = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      T5: begin
        reg_out = rc_onehot;
        alu_sel = dec_alu_sel;
        z_in    = 1'b1;
      end
      T6: begin
        z_low_out = 1'b1;
        reg_in    = ra_onehot;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
